// File: rtl/usbf_tx_seq_pkg.sv
// Shared definitions for the USB function IN-packet TX sequencer.
// State encodings are fixed values so they match existing register dumps.
package usbf_tx_seq_pkg;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE = 2'd0;
    localparam tx_state_t ST_RUN  = 2'd1;
    localparam tx_state_t ST_DONE = 2'd2;

    localparam int MPS_W_DEF = 11;

endpackage

// File: rtl/usbf_tx_seq.sv
// Drains one IN packet from the selected endpoint TX FIFO into a valid/ready byte stream.
// Optional ready-stall watchdog enabled by defining USBF_TX_SEQ_TIMEOUT_EN.
module usbf_tx_seq
    import usbf_tx_seq_pkg::*;
#(
    parameter int EP_NUM  = 4,
    parameter int DATA_W  = 8,
    parameter int MPS_W   = MPS_W_DEF,
    parameter int EP_W    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                     phy_clk_i,
    input  logic                     rstn_i,
    input  logic                     start_i,
    input  logic [EP_W-1:0]          ep_sel_i,
    input  logic [MPS_W-1:0]         mps_i,
    input  logic                     abort_i,
    input  logic [EP_NUM-1:0]        tx_empty_i,
    input  logic [DATA_W*EP_NUM-1:0] tx_data_i,
    output logic [EP_NUM-1:0]        rd_req_o,
    output logic                     out_valid_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     out_last_o,
    input  logic                     out_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     zlp_o,
    output logic [MPS_W-1:0]         byte_cnt_o,
    output logic                     timeout_o
);

    tx_state_t         state_q;
    logic [EP_W-1:0]   sel_q;
    logic [MPS_W-1:0]  mps_q;
    logic [MPS_W-1:0]  fetched_q;
    logic [MPS_W-1:0]  sent_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    logic              sel_valid;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_byte;
    logic              run;
    logic              last;
    logic              handshake;
    logic              pop;
    logic              zlp_go;
    logic              timeout_hit;
    logic              abort_eff;

    // An out-of-range endpoint looks like a permanently empty FIFO, so it ends as a ZLP.
    assign sel_valid  = int'(sel_q) < EP_NUM;
    assign fifo_empty = sel_valid ? tx_empty_i[sel_q] : 1'b1;
    assign head_byte  = sel_valid ? tx_data_i[int'(sel_q)*DATA_W +: DATA_W] : '0;

    assign run       = (state_q == ST_RUN);
    assign abort_eff = abort_i | timeout_hit;
    assign last      = out_valid_q && ((fetched_q == mps_q) || fifo_empty);
    assign handshake = out_valid_q && out_ready_i;

    // Refill the output register when it is empty or is being drained by a non-final byte.
    assign pop = run && !abort_eff && sel_valid && !fifo_empty && (fetched_q < mps_q) &&
                 (!out_valid_q || (out_ready_i && !last));

    assign zlp_go = run && !abort_eff && (fetched_q == '0) && !out_valid_q &&
                    ((mps_q == '0) || fifo_empty);

    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    always_comb begin
        rd_req_o = '0;
        if (pop) begin
            rd_req_o[sel_q] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge phy_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            mps_q       <= '0;
            fetched_q   <= '0;
            sent_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (abort_eff) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        sel_q     <= ep_sel_i;
                        mps_q     <= mps_i;
                        fetched_q <= '0;
                        sent_q    <= '0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        out_data_q  <= head_byte;
                        fetched_q   <= fetched_q + MPS_W'(1);
                        out_valid_q <= 1'b1;
                    end
                    if (handshake) begin
                        sent_q <= sent_q + MPS_W'(1);
                        if (last) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_DONE;
                        end
                    end
                    if (zlp_go) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef USBF_TX_SEQ_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q;

    // Saturates at TIMEOUT; the cycle it sits there acts as an abort and clears it.
    always_ff @(posedge phy_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_q <= '0;
        end else if (!run || !out_valid_q || out_ready_i || abort_eff) begin
            stall_q <= '0;
        end else if (stall_q != STALL_W'(TIMEOUT)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign timeout_hit = run && (stall_q == STALL_W'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = last;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign zlp_o       = done_o && (sent_q == '0);
    assign byte_cnt_o  = sent_q;
    assign timeout_o   = timeout_hit;

endmodule

// File: tb/tb_usbf_tx_seq.sv
// Scoreboard bench for usbf_tx_seq: FIFO model feeds the DUT, expected bytes are queued at load time.
// Stall expectations follow USBF_TX_SEQ_TIMEOUT_EN when it is defined for the build.
module tb_usbf_tx_seq;

    localparam int EP_NUM = 4;
    localparam int DATA_W = 8;
    localparam int MPS_W  = 11;
    localparam int EP_W   = 2;

    logic                     phy_clk_i = 1'b0;
    logic                     rstn_i;
    logic                     start_i;
    logic [EP_W-1:0]          ep_sel_i;
    logic [MPS_W-1:0]         mps_i;
    logic                     abort_i;
    logic [EP_NUM-1:0]        tx_empty_i;
    logic [DATA_W*EP_NUM-1:0] tx_data_i;
    logic [EP_NUM-1:0]        rd_req_o;
    logic                     out_valid_o;
    logic [DATA_W-1:0]        out_data_o;
    logic                     out_last_o;
    logic                     out_ready_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     zlp_o;
    logic [MPS_W-1:0]         byte_cnt_o;
    logic                     timeout_o;

    always #5 phy_clk_i = ~phy_clk_i;

    usbf_tx_seq #(
        .EP_NUM(EP_NUM), .DATA_W(DATA_W), .MPS_W(MPS_W), .EP_W(EP_W), .TIMEOUT(16)
    ) dut (
        .phy_clk_i(phy_clk_i), .rstn_i(rstn_i), .start_i(start_i), .ep_sel_i(ep_sel_i),
        .mps_i(mps_i), .abort_i(abort_i), .tx_empty_i(tx_empty_i), .tx_data_i(tx_data_i),
        .rd_req_o(rd_req_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o),
        .zlp_o(zlp_o), .byte_cnt_o(byte_cnt_o), .timeout_o(timeout_o)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] fifo [EP_NUM][$];
    exp_t              exp_q[$];

    int                cyc;
    int                done_cnt;
    int                done_cyc;
    int                hs_cnt;
    int                first_req_cyc;
    int                first_valid_cyc;
    int                pop_cnt [EP_NUM];
    logic              seen_zlp;
    logic [MPS_W-1:0]  seen_cnt;
    bit                timeout_seen;
    logic [EP_NUM-1:0] allowed_req;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;

    task automatic refresh_fifo();
        for (int e = 0; e < EP_NUM; e++) begin
            tx_empty_i[e] = (fifo[e].size() == 0);
            tx_data_i[e*DATA_W +: DATA_W] = (fifo[e].size() != 0) ? fifo[e][0] : '0;
        end
    endtask

    // One clock: sample outputs before the edge, apply FIFO pops just after it.
    task automatic tick();
        logic [EP_NUM-1:0] req;
        exp_t              e;
        refresh_fifo();
        #1;
        req = rd_req_o;
        if (req != 0 && first_req_cyc < 0) first_req_cyc = cyc;
        if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        checks++;
        if ((req & ~allowed_req) != 0) begin
            failures++;
            $display("FAIL rd_req_sel cyc=%0d: got %b allowed %b", cyc, req, allowed_req);
        end
        if (out_valid_o && !out_ready_i) begin
            checks++;
            if (req != 0) begin
                failures++;
                $display("FAIL pop_in_stall cyc=%0d: got rd_req %b expected 0", cyc, req);
            end
        end
        if (prev_stall) begin
            checks++;
            if (out_data_o !== prev_data) begin
                failures++;
                $display("FAIL data_hold cyc=%0d: got %h expected %h", cyc, out_data_o, prev_data);
            end
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_data  = out_data_o;
        if (out_valid_o && out_ready_i) begin
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stream_extra cyc=%0d: got byte %h expected none", cyc, out_data_o);
            end else begin
                e = exp_q.pop_front();
                if (out_data_o !== e.data || out_last_o !== e.last) begin
                    failures++;
                    $display("FAIL stream_byte cyc=%0d: got %h/last=%b expected %h/last=%b",
                             cyc, out_data_o, out_last_o, e.data, e.last);
                end
            end
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            seen_zlp = zlp_o;
            seen_cnt = byte_cnt_o;
        end
        if (timeout_o) timeout_seen = 1'b1;
        @(posedge phy_clk_i);
        #1;
        for (int p = 0; p < EP_NUM; p++) begin
            if (req[p] && fifo[p].size() != 0) begin
                void'(fifo[p].pop_front());
                pop_cnt[p]++;
            end
        end
        refresh_fifo();
        cyc++;
        @(negedge phy_clk_i);
    endtask

    task automatic reset_monitor(input int ep);
        cyc             = 0;
        done_cnt        = 0;
        done_cyc        = -1;
        hs_cnt          = 0;
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        timeout_seen    = 1'b0;
        prev_stall      = 1'b0;
        allowed_req     = EP_NUM'(1) << ep;
        for (int p = 0; p < EP_NUM; p++) pop_cnt[p] = 0;
    endtask

    task automatic load_fifo(input int ep, input int n);
        for (int i = 0; i < n; i++) fifo[ep].push_back(DATA_W'($urandom_range(0, 255)));
    endtask

    task automatic start_pkt(input int ep, input int mps);
        ep_sel_i = EP_W'(ep);
        mps_i    = MPS_W'(mps);
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    // Full packet: expected bytes come from the FIFO model contents at start time.
    task automatic run_packet(input string name, input int ep, input int n_new, input int mps,
                              input bit toggle);
        int total;
        int k;
        exp_t e;
        reset_monitor(ep);
        load_fifo(ep, n_new);
        total = fifo[ep].size();
        k = (total < mps) ? total : mps;
        for (int i = 0; i < k; i++) begin
            e.data = fifo[ep][i];
            e.last = (i == k - 1);
            exp_q.push_back(e);
        end
        out_ready_i = 1'b1;
        start_pkt(ep, mps);
        for (int i = 0; i < 200 && done_cnt == 0; i++) begin
            if (toggle) out_ready_i = (cyc % 2 == 0);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (seen_cnt !== MPS_W'(k) || seen_zlp !== (k == 0)) begin
            failures++;
            $display("FAIL %s byte_cnt/zlp: got %0d/%b expected %0d/%b",
                     name, seen_cnt, seen_zlp, k, (k == 0));
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s bytes_missing: got %0d left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (pop_cnt[ep] != k || fifo[ep].size() != total - k) begin
            failures++;
            $display("FAIL %s pops: got %0d (fifo %0d) expected %0d (fifo %0d)",
                     name, pop_cnt[ep], fifo[ep].size(), k, total - k);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after_done: got busy %b expected 0", name, busy_o);
        end
        if (!toggle) begin
            checks++;
            if (done_cyc != ((k == 0) ? 2 : k + 2)) begin
                failures++;
                $display("FAIL %s done_latency: got %0d expected %0d",
                         name, done_cyc, (k == 0) ? 2 : k + 2);
            end
            if (k > 0) begin
                checks++;
                if (first_req_cyc != 1 || first_valid_cyc != 2) begin
                    failures++;
                    $display("FAIL %s start_latency: got req@%0d valid@%0d expected 1 and 2",
                             name, first_req_cyc, first_valid_cyc);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn_i      = 1'b0;
        start_i     = 1'b0;
        ep_sel_i    = '0;
        mps_i       = '0;
        abort_i     = 1'b0;
        out_ready_i = 1'b0;
        refresh_fifo();
        repeat (2) @(negedge phy_clk_i);
        checks++;
        if ({rd_req_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o, zlp_o,
             byte_cnt_o, timeout_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%b v=%b d=%h l=%b b=%b dn=%b z=%b c=%0d t=%b expected all 0",
                     rd_req_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o, zlp_o,
                     byte_cnt_o, timeout_o);
        end
        rstn_i = 1'b1;
        @(negedge phy_clk_i);
    endtask

    task automatic test_basic();
        run_packet("ep1_short", 1, 5, 64, 1'b0);
        run_packet("ep0_mps_limit", 0, 10, 8, 1'b0);
        checks++;
        if (tx_empty_i[0] !== 1'b0) begin
            failures++;
            $display("FAIL ep0_remaining: got empty %b expected 0", tx_empty_i[0]);
        end
    endtask

    task automatic test_zlp();
        run_packet("ep2_empty_zlp", 2, 0, 64, 1'b0);
        run_packet("ep3_mps0_zlp", 3, 4, 0, 1'b0);
        fifo[3].delete();
    endtask

    task automatic test_back_to_back();
        run_packet("ep0_leftover", 0, 0, 8, 1'b0);
        run_packet("ep1_exact_mps", 1, 4, 4, 1'b0);
    endtask

    task automatic test_ready_toggle();
        run_packet("ep2_toggle", 2, 4, 64, 1'b1);
    endtask

    task automatic test_abort();
        exp_t e;
        reset_monitor(3);
        load_fifo(3, 6);
        for (int i = 0; i < 6; i++) begin
            e.data = fifo[3][i];
            e.last = (i == 5);
            exp_q.push_back(e);
        end
        out_ready_i = 1'b1;
        start_pkt(3, 64);
        for (int i = 0; i < 20 && hs_cnt < 3; i++) tick();
        abort_i = 1'b1;
        refresh_fifo();
        #1;
        checks++;
        if (rd_req_o !== '0) begin
            failures++;
            $display("FAIL abort_no_pop: got %b expected 0", rd_req_o);
        end
        tick();
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b valid=%b expected 0/0", busy_o, out_valid_o);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt != 0 || hs_cnt != 4) begin
            failures++;
            $display("FAIL abort_no_done: got done=%0d bytes=%0d expected 0/4", done_cnt, hs_cnt);
        end
        exp_q.delete();
        fifo[3].delete();
        run_packet("after_abort", 1, 3, 64, 1'b0);
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] first;
        reset_monitor(0);
        fifo[0].delete();
        load_fifo(0, 3);
        first = fifo[0][0];
        out_ready_i = 1'b0;
        start_pkt(0, 64);
        repeat (40) tick();
`ifdef USBF_TX_SEQ_TIMEOUT_EN
        checks++;
        if (!timeout_seen || busy_o !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL stall_timeout: got to=%b busy=%b done=%0d expected 1/0/0",
                     timeout_seen, busy_o, done_cnt);
        end
`else
        checks++;
        if (busy_o !== 1'b1 || out_valid_o !== 1'b1 || timeout_seen) begin
            failures++;
            $display("FAIL stall_hold: got busy=%b valid=%b to=%b expected 1/1/0",
                     busy_o, out_valid_o, timeout_seen);
        end
`endif
        checks++;
        if (out_data_o !== first || pop_cnt[0] != 1) begin
            failures++;
            $display("FAIL stall_data: got %h pops=%0d expected %h pops=1", out_data_o, pop_cnt[0], first);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        fifo[0].delete();
        tick();
    endtask

    initial begin
        for (int e = 0; e < EP_NUM; e++) fifo[e].delete();
        reset_monitor(0);
        test_reset();
        test_basic();
        test_zlp();
        test_back_to_back();
        test_ready_toggle();
        test_abort();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
